// File: rtl/lsu_request_retire.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : lsu_request_retire
// Description : LSU issue buffer. Sends queued load/store instructions to data
//               memory one at a time, waits for each response, then pulses a
//               retire to the scheduler's scoreboard with the warp and mask.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_request_retire #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MASK_WIDTH = 4,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic [1:0]               issue_warp_i,
    input  logic [MASK_WIDTH-1:0]    issue_mask_i,
    input  logic                     issue_is_store_i,
    input  logic [ADDR_WIDTH-1:0]    issue_addr_i,

    output logic                     mem_req_valid_o,
    input  logic                     mem_req_ready_i,
    output logic                     mem_req_we_o,
    output logic [ADDR_WIDTH-1:0]    mem_req_addr_o,
    output logic [1:0]               mem_req_warp_o,
    input  logic                     mem_resp_valid_i,

    output logic                     done_bit_o,
    output logic [1:0]               warp_num_clear_o,
    output logic [MASK_WIDTH-1:0]    threads_mask_clear_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE     = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_WAIT_RESP = 2'd2,
        S_RETIRE    = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [PTR_W:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]         rd_ptr_q, rd_ptr_d;

    logic [1:0]             warp_q  [DEPTH];
    logic [MASK_WIDTH-1:0]  mask_q  [DEPTH];
    logic                   we_q    [DEPTH];
    logic [ADDR_WIDTH-1:0]  addr_q  [DEPTH];

    logic [PTR_W:0]         count;
    logic [PTR_W-1:0]       wr_idx;
    logic [PTR_W-1:0]       rd_idx;
    logic                   empty;
    logic                   push;
    logic                   pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign count         = wr_ptr_q - rd_ptr_q;
    assign wr_idx        = wr_ptr_q[PTR_W-1:0];
    assign rd_idx        = rd_ptr_q[PTR_W-1:0];
    assign empty         = (count == '0);
    assign issue_ready_o = (count != DEPTH_COUNT);
    assign occupancy_o   = count;

    assign push = issue_valid_i && issue_ready_o;
    assign pop  = (state_q == S_RETIRE);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // An empty thread mask has nothing to fetch, so skip memory.
                if (!empty) begin
                    state_d = (mask_q[rd_idx] == '0) ? S_RETIRE : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready_i) begin
                    state_d = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (mem_resp_valid_i) begin
                    state_d = S_RETIRE;
                end
            end
            S_RETIRE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_req_valid_o      = 1'b0;
        mem_req_we_o         = 1'b0;
        mem_req_addr_o       = '0;
        mem_req_warp_o       = '0;
        done_bit_o           = 1'b0;
        warp_num_clear_o     = '0;
        threads_mask_clear_o = '0;
        case (state_q)
            S_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_we_o    = we_q[rd_idx];
                mem_req_addr_o  = addr_q[rd_idx];
                mem_req_warp_o  = warp_q[rd_idx];
            end
            S_RETIRE: begin
                done_bit_o           = 1'b1;
                warp_num_clear_o     = warp_q[rd_idx];
                threads_mask_clear_o = mask_q[rd_idx];
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                warp_q[i] <= '0;
                mask_q[i] <= '0;
                we_q[i]   <= 1'b0;
                addr_q[i] <= '0;
            end
        end else if (push) begin
            warp_q[wr_idx] <= issue_warp_i;
            mask_q[wr_idx] <= issue_mask_i;
            we_q[wr_idx]   <= issue_is_store_i;
            addr_q[wr_idx] <= issue_addr_i;
        end
    end

endmodule
`default_nettype wire
